memory_arbiter: RTL and testbench



---
 rtl/memarb_pkg.sv | 27 ++
 rtl/memarb_watchdog.sv | 36 +++
 rtl/memory_arbiter.sv | 137 +++++++++++++
 tb/tb_memory_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// memarb_pkg: shared types for the memory arbiter.
//   ramstate_t  - RAM status encoding presented on the ramstate input
//   arb_state_t - arbiter FSM states
//   addr_t/word_t - default-width address and word types
package memarb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/memarb_watchdog.sv
// memarb_watchdog: access timeout counter for the memory arbiter.
//   CLK     - system clock
//   RST     - synchronous active-high reset
//   start   - access state is being entered this cycle (clears the count)
//   active  - FSM is in an access state this cycle (count advances)
//   expired - this is the TIMEOUT_CYCLES-th access cycle
// Only built when MEMARB_TIMEOUT_EN is defined.
module memarb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  input  logic active,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (active && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The count holds the number of access cycles already completed, so the
  // final permitted cycle is the one where it equals TIMEOUT_CYCLES-1.
  assign expired = active && (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises instruction fetches and data accesses onto a
// single RAM port. Data requests win over fetches. Each access ends with a
// one-cycle DONE state carrying the ihit/dhit pulse and load data.
//   CLK, RST                         - clock, synchronous active-high reset
//   iREN, iaddr                      - fetch request
//   dREN, dWEN, daddr, dstore        - data request (dWEN wins over dREN)
//   ihit, iload / dhit, dload        - completion pulses and load data
//   ramREN, ramWEN, ramaddr, ramstore, ramload, ramstate - RAM port
//   memerr                           - access ended in ERROR or timed out
// Optional: define MEMARB_TIMEOUT_EN to enable the access watchdog.
module memory_arbiter
  import memarb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              memerr
);

  arb_state_t  state;
  ramstate_t   rs;
  logic        is_write;
  logic        timeout;
  logic        finish;
  logic [DATA_W-1:0] load_val;

  assign rs = ramstate_t'(ramstate);

`ifdef MEMARB_TIMEOUT_EN
  logic wd_start;
  logic wd_active;

  assign wd_start  = (state == IDLE) && (dREN || dWEN || iREN);
  assign wd_active = (state == DACC) || (state == IACC);

  memarb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .CLK    (CLK),
    .RST    (RST),
    .start  (wd_start),
    .active (wd_active),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign finish   = (rs == ACCESS) || (rs == ERROR) || timeout;
  // A completed access returns RAM data; an error or timeout returns 0.
  assign load_val = (rs == ACCESS) ? ramload : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      is_write <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      memerr   <= 1'b0;
      iload    <= '0;
      dload    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ihit   <= 1'b0;
          dhit   <= 1'b0;
          memerr <= 1'b0;
          if (dREN || dWEN) begin
            state    <= DACC;
            is_write <= dWEN;
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= ~dWEN;
          end else if (iREN) begin
            state    <= IACC;
            is_write <= 1'b0;
            ramaddr  <= iaddr;
            ramstore <= '0;
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
          end
        end
        DACC, IACC: begin
          if (finish) begin
            state    <= DONE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            memerr   <= (rs != ACCESS);
            if (state == DACC) begin
              dhit  <= 1'b1;
              dload <= is_write ? '0 : load_val;
            end else begin
              ihit  <= 1'b1;
              iload <= load_val;
            end
          end
        end
        DONE: begin
          // Request unit drops its strobes on the edge that enters DONE, so
          // going straight back to IDLE cannot re-issue the same access.
          state  <= IDLE;
          ihit   <= 1'b0;
          dhit   <= 1'b0;
          memerr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import memarb_pkg::*;

`ifdef MEMARB_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 64;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        ihit, dhit, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = 2'd0;

  memory_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;
  int hits = 0;

  // RAM model configuration, set by the stimulus before each request.
  int        busy_left = 0;
  ramstate_t final_st = ACCESS;
  logic [31:0] rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RAM responder: BUSY for busy_left strobed cycles, then final_st.
  initial forever begin
    @(negedge CLK);
    if (ramREN || ramWEN) begin
      if (busy_left > 0) begin
        ramstate = BUSY;
        busy_left--;
      end else begin
        ramstate = final_st;
        ramload  = rdata;
      end
    end else begin
      ramstate = FREE;
      ramload  = '0;
    end
  end

  // Scoreboard monitor: every hit pops and checks one expectation.
  initial forever begin
    @(negedge CLK);
    if (ihit || dhit) begin
      hits++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hit: ihit=%0b dhit=%0b, expected no hit", ihit, dhit);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("hit_src_is_d", {31'b0, dhit}, {31'b0, e.is_d});
        chk("hit_onehot", {31'b0, ihit & dhit}, 32'd0);
        chk("hit_data", dhit ? dload : iload, e.data);
        chk("hit_memerr", {31'b0, memerr}, {31'b0, e.err});
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (expq.size() == 0 && !ihit && !dhit) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_drain: %0d hits still pending after 40 cycles, expected 0", name,
             expq.size());
  endtask

  initial begin
    int n;
    int td;
    int ti;
    int h0;
    logic rd_seen;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_dhit", {31'b0, dhit}, 32'd0);
    chk("rst_ramREN", {31'b0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_memerr", {31'b0, memerr}, 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Single fetch with two wait states
    busy_left = 2; final_st = ACCESS; rdata = 32'h2108000C;
    expq.push_back(exp_t'{1'b0, 32'h2108000C, 1'b0});
    iaddr = 32'h40; iREN = 1'b1;
    @(negedge CLK);
    iREN = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && ramREN; i++) begin
      chk("fetch_ramaddr", ramaddr, 32'h40);
      n++;
      @(negedge CLK);
    end
    chk("fetch_ren_cycles", 32'(n), 32'd3);
    wait_drain("fetch");

    // Simultaneous data read and fetch: data first, fetch 3 cycles later
    busy_left = 0; final_st = ACCESS; rdata = 32'h0BADF00D;
    expq.push_back(exp_t'{1'b1, 32'h0BADF00D, 1'b0});
    expq.push_back(exp_t'{1'b0, 32'h0BADF00D, 1'b0});
    daddr = 32'h100; dREN = 1'b1; iaddr = 32'h44; iREN = 1'b1;
    td = -1; ti = -1;
    for (int c = 0; c < 30 && ti < 0; c++) begin
      @(negedge CLK);
      if (dhit && td < 0) begin td = c; dREN = 1'b0; end
      if (ihit) begin ti = c; iREN = 1'b0; end
    end
    dREN = 1'b0; iREN = 1'b0;
    chk("prio_d_before_i", {31'b0, (td >= 0) && (ti > td)}, 32'd1);
    chk("prio_hit_spacing", 32'(ti - td), 32'd3);
    wait_drain("prio");

    // Reset during a data access: no hit, outputs cleared
    busy_left = 0; final_st = BUSY;
    daddr = 32'h300; dREN = 1'b1;
    @(negedge CLK);
    dREN = 1'b0;
    chk("rstmid_ramREN_before", {31'b0, ramREN}, 32'd1);
    chk("rstmid_ramaddr_before", ramaddr, 32'h300);
    h0 = hits;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rstmid_ramREN", {31'b0, ramREN}, 32'd0);
    chk("rstmid_ramaddr", ramaddr, 32'd0);
    chk("rstmid_dhit", {31'b0, dhit}, 32'd0);
    chk("rstmid_dload", dload, 32'd0);
    repeat (5) @(negedge CLK);
    chk("rstmid_no_hit", 32'(hits - h0), 32'd0);
    final_st = ACCESS;

    // Store: write strobe only, dload returns 0
    busy_left = 1; final_st = ACCESS; rdata = 32'h5555AAAA;
    expq.push_back(exp_t'{1'b1, 32'h0, 1'b0});
    daddr = 32'h200; dstore = 32'hDEADBEEF; dWEN = 1'b1;
    @(negedge CLK);
    dWEN = 1'b0;
    n = 0; rd_seen = 1'b0;
    for (int i = 0; i < 20 && ramWEN; i++) begin
      chk("store_ramstore", ramstore, 32'hDEADBEEF);
      chk("store_ramaddr", ramaddr, 32'h200);
      if (ramREN) rd_seen = 1'b1;
      n++;
      @(negedge CLK);
    end
    chk("store_wen_cycles", 32'(n), 32'd2);
    chk("store_no_ren", {31'b0, rd_seen}, 32'd0);
    wait_drain("store");

    // Error response during fetch
    busy_left = 1; final_st = ERROR; rdata = 32'h12345678;
    expq.push_back(exp_t'{1'b0, 32'h0, 1'b1});
    iaddr = 32'h80; iREN = 1'b1;
    @(negedge CLK);
    iREN = 1'b0;
    wait_drain("error");
    final_st = ACCESS;

    // RAM stuck BUSY
    busy_left = 0; final_st = BUSY;
    iaddr = 32'h84; iREN = 1'b1;
`ifdef MEMARB_TIMEOUT_EN
    expq.push_back(exp_t'{1'b0, 32'h0, 1'b1});
    @(negedge CLK);
    iREN = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && ramREN; i++) begin
      n++;
      @(negedge CLK);
    end
    chk("timeout_access_cycles", 32'(n), 32'd4);
    wait_drain("timeout");
`else
    @(negedge CLK);
    iREN = 1'b0;
    h0 = hits;
    repeat (100) @(negedge CLK);
    chk("stuck_no_hit", 32'(hits - h0), 32'd0);
    chk("stuck_still_reading", {31'b0, ramREN}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
`endif
    final_st = ACCESS;

    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
